nibble_cpu_core: RTL

- Parametrised successor to the single-step 4-bit teaching CPU.
- Accumulator machine:
  - registers A and B of DATA_W bits; zero and carry flags; PC_W-bit program counter.
  - external combinational program ROM.
  - conditional/unconditional jumps and a HALT state.
- Runs synchronously on clk and advances one instruction per cycle when step_en is high.
  - step_en comes from a debounced button pulse for single-step, or is tied high for free-run.
- Sits between the board-level clock/debounce logic and LED outputs.

---
 rtl/nibble_cpu_pkg.sv | 45 ++++
 rtl/nibble_cpu_core_alu.sv | 38 +++
 rtl/nibble_cpu_core.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nibble_cpu_pkg.sv
// Shared encodings for the nibble accumulator CPU: opcodes, ALU sub-ops and run state.
package nibble_cpu_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned ALU_OP_W = 3;

    localparam logic [OPC_W-1:0] OP_NOP     = 4'b0000;
    localparam logic [OPC_W-1:0] OP_LD_A    = 4'b0001;
    localparam logic [OPC_W-1:0] OP_LD_B    = 4'b0010;
    localparam logic [OPC_W-1:0] OP_MOV_B_A = 4'b0011;
    localparam logic [OPC_W-1:0] OP_JMP     = 4'b0100;
    localparam logic [OPC_W-1:0] OP_JZ      = 4'b0101;
    localparam logic [OPC_W-1:0] OP_JC      = 4'b0110;
    localparam logic [OPC_W-1:0] OP_HALT    = 4'b0111;
    localparam logic [OPC_W-1:0] OP_ADD     = 4'b1000;
    localparam logic [OPC_W-1:0] OP_SUB     = 4'b1001;
    localparam logic [OPC_W-1:0] OP_AND     = 4'b1010;
    localparam logic [OPC_W-1:0] OP_OR      = 4'b1011;
    localparam logic [OPC_W-1:0] OP_XOR     = 4'b1100;
    localparam logic [OPC_W-1:0] OP_SHL     = 4'b1101;
    localparam logic [OPC_W-1:0] OP_SHR     = 4'b1110;
    localparam logic [OPC_W-1:0] OP_INC     = 4'b1111;

    // Every opcode of the form 1xxx is an ALU op; the low three bits pick the function.
    localparam logic [OPC_W-1:0] OP_ALU_MASK = 4'b1000;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_SHL = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_SHR = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_INC = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        return (op & OP_ALU_MASK) == OP_ALU_MASK;
    endfunction

endpackage

// File: rtl/nibble_cpu_core_alu.sv
// Combinational ALU: result, zero and carry/borrow for the eight 1xxx opcodes.
module nibble_cpu_alu
    import nibble_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic [ALU_OP_W-1:0] i_op,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [DATA_W-1:0]   o_result_c,
    output logic                o_zf_c,
    output logic                o_cf_c
);

    localparam int unsigned EXT_W = DATA_W + 1;

    // Top bit of the extended result is the carry-out / borrow / shifted-out bit.
    logic [EXT_W-1:0] w_ext;

    always_comb begin
        w_ext = '0;
        unique case (i_op)
            ALU_ADD: w_ext = {1'b0, i_a} + {1'b0, i_b};
            ALU_SUB: w_ext = {1'b0, i_a} - {1'b0, i_b};
            ALU_AND: w_ext = {1'b0, i_a & i_b};
            ALU_OR:  w_ext = {1'b0, i_a | i_b};
            ALU_XOR: w_ext = {1'b0, i_a ^ i_b};
            ALU_SHL: w_ext = {i_a, 1'b0};
            ALU_SHR: w_ext = {i_a[0], 1'b0, i_a[DATA_W-1:1]};
            ALU_INC: w_ext = {1'b0, i_a} + EXT_W'(1);
        endcase
    end

    assign o_result_c = w_ext[DATA_W-1:0];
    assign o_cf_c     = w_ext[DATA_W];
    assign o_zf_c     = (w_ext[DATA_W-1:0] == '0);

endmodule

// File: rtl/nibble_cpu_core.sv
// Single-cycle accumulator CPU with RUN/HALT state, stepped by step_en.
// Define NIBBLE_CPU_CALL_EN to add the single-level CALL/RET link register on opcode 0000.
module nibble_cpu_core
    import nibble_cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned PC_W     = 3,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                step_en,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [DATA_W+3:0]   imem_data,
    output logic [DATA_W-1:0]   a_reg,
    output logic [DATA_W-1:0]   b_reg,
    output logic                zf,
    output logic                cf,
    output logic [PC_W-1:0]     pc,
`ifdef NIBBLE_CPU_CALL_EN
    output logic [PC_W-1:0]     link_reg,
`endif
    output logic                halted
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_zf;
    logic                r_cf;
    logic [PC_W-1:0]     r_pc;
    logic                r_halted;

    logic [OPC_W-1:0]    w_opcode;
    logic [DATA_W-1:0]   w_arg;
    logic [PC_W-1:0]     w_target;
    logic [PC_W-1:0]     w_pc_inc;
    logic [PC_W-1:0]     w_pc_next;
    logic [DATA_W-1:0]   w_alu_result;
    logic                w_alu_zf;
    logic                w_alu_cf;

    assign w_opcode = imem_data[DATA_W+3:DATA_W];
    assign w_arg    = imem_data[DATA_W-1:0];
    assign w_target = w_arg[PC_W-1:0];
    assign w_pc_inc = r_pc + PC_W'(1);

`ifdef NIBBLE_CPU_CALL_EN
    localparam logic [DATA_W-1:0] LOW_MASK = {1'b0, {(DATA_W-1){1'b1}}};

    logic [PC_W-1:0] r_link;
    logic            w_call_sel;
    logic            w_ret_sel;

    // arg MSB set marks CALL (low bits zero) or RET (low bits nonzero); CALL target comes from B.
    assign w_call_sel = w_arg[DATA_W-1] && ((w_arg & LOW_MASK) == '0);
    assign w_ret_sel  = w_arg[DATA_W-1] && ((w_arg & LOW_MASK) != '0);
    assign link_reg   = r_link;
`endif

    nibble_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op       (w_opcode[ALU_OP_W-1:0]),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_result_c (w_alu_result),
        .o_zf_c     (w_alu_zf),
        .o_cf_c     (w_alu_cf)
    );

    // Next PC: jumps test the flags as registered by earlier instructions.
    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_opcode)
            OP_JMP:  w_pc_next = w_target;
            OP_JZ:   if (r_zf) w_pc_next = w_target;
            OP_JC:   if (r_cf) w_pc_next = w_target;
            OP_HALT: w_pc_next = r_pc;
`ifdef NIBBLE_CPU_CALL_EN
            OP_NOP: begin
                if (w_call_sel) begin
                    w_pc_next = r_b[PC_W-1:0];
                end else if (w_ret_sel) begin
                    w_pc_next = r_link;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_RUN;
            r_a      <= '0;
            r_b      <= '0;
            r_zf     <= 1'b0;
            r_cf     <= 1'b0;
            r_pc     <= PC_W'(RESET_PC);
            r_halted <= 1'b0;
`ifdef NIBBLE_CPU_CALL_EN
            r_link   <= '0;
`endif
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (step_en) begin
                        r_pc <= w_pc_next;
                        if (is_alu_op(w_opcode)) begin
                            r_a  <= w_alu_result;
                            r_zf <= w_alu_zf;
                            r_cf <= w_alu_cf;
                        end else begin
                            case (w_opcode)
                                OP_LD_A:    r_a <= w_arg;
                                OP_LD_B:    r_b <= w_arg;
                                OP_MOV_B_A: r_b <= r_a;
                                OP_HALT: begin
                                    r_state  <= ST_HALT;
                                    r_halted <= 1'b1;
                                end
`ifdef NIBBLE_CPU_CALL_EN
                                OP_NOP:     if (w_call_sel) r_link <= w_pc_inc;
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                ST_HALT: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign a_reg     = r_a;
    assign b_reg     = r_b;
    assign zf        = r_zf;
    assign cf        = r_cf;
    assign pc        = r_pc;
    assign halted    = r_halted;

endmodule
